// File: rtl/uart_max_value_framer_if.sv
// Signal bundle between the max-value framer, the UART RX/TX pair and the max-value cache.
// The framer uses the master view. The UART/cache side uses the slave view.
interface uart_max_value_framer_if;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic [9:0] max_value;
  logic [2:0] channel_sel;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       tx_write_en;
  logic       tx_ready;
  logic       busy;
  logic [7:0] bad_cmd_count;
  logic       timeout_flag;

  modport master (
    input  rx_data, rx_ready, max_value, tx_ready,
    output channel_sel, tx_data, tx_en, tx_write_en, busy, bad_cmd_count, timeout_flag
  );

  modport slave (
    output rx_data, rx_ready, max_value, tx_ready,
    input  channel_sel, tx_data, tx_en, tx_write_en, busy, bad_cmd_count, timeout_flag
  );
endinterface

// File: rtl/uart_max_value_framer.sv
// Turns an ASCII channel command into a framed 5-byte reply that carries the full 10-bit value.
// Frame layout: header, channel, value high, value low, XOR checksum. Unknown commands get an error frame.
module uart_max_value_framer #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned TX_TIMEOUT    = 65535,
  parameter logic [7:0]  HEADER        = 8'hA5
) (
  input  logic                    i_clk,
  input  logic                    i_reset_b,
  uart_max_value_framer_if.master bus
);

  localparam int unsigned TimeoutW = $clog2(TX_TIMEOUT + 1);
  localparam int unsigned TimerW   = (TimeoutW > 4) ? TimeoutW : 4;
  localparam logic [TimerW-1:0] SettleLast  = TimerW'(SETTLE_CYCLES - 1);
  localparam logic [TimerW-1:0] TimeoutLast = TimerW'(TX_TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StSelect, StLatch, StLoad, StWaitDone} state_e;

  state_e            r_state, w_state_next;
  logic              r_rx_ready_prev;
  logic [7:0]        r_cmd, w_cmd_next;
  logic              r_cmd_valid, w_cmd_valid_next;
  logic [2:0]        r_channel_sel, w_channel_sel_next;
  logic [9:0]        r_value, w_value_next;
  logic [2:0]        r_idx, w_idx_next;
  logic [TimerW-1:0] r_timer, w_timer_next;
  logic [7:0]        r_tx_data, w_tx_data_next;
  logic [7:0]        r_bad_cnt, w_bad_cnt_next;
  logic              r_timeout, w_timeout_next;

  logic       w_edge, w_cmd_in_valid;
  logic [7:0] w_b1, w_b2, w_b3, w_b4, w_next_byte;

  assign w_edge         = bus.rx_ready & ~r_rx_ready_prev;
  assign w_cmd_in_valid = (bus.rx_data >= 8'h31) && (bus.rx_data <= 8'h34);

  // Frame bytes come only from state frozen at accept/latch time.
  assign w_b1 = r_cmd_valid ? (r_cmd + 8'h10) : 8'h3F;
  assign w_b2 = r_cmd_valid ? {6'b0, r_value[9:8]} : 8'h00;
  assign w_b3 = r_cmd_valid ? r_value[7:0] : r_cmd;
  assign w_b4 = HEADER ^ w_b1 ^ w_b2 ^ w_b3;

  always_comb begin
    w_next_byte = w_b4;
    case (r_idx)
      3'd0:    w_next_byte = w_b1;
      3'd1:    w_next_byte = w_b2;
      3'd2:    w_next_byte = w_b3;
      default: w_next_byte = w_b4;
    endcase
  end

  always_comb begin
    w_state_next       = r_state;
    w_cmd_next         = r_cmd;
    w_cmd_valid_next   = r_cmd_valid;
    w_channel_sel_next = r_channel_sel;
    w_value_next       = r_value;
    w_idx_next         = r_idx;
    w_timer_next       = r_timer;
    w_tx_data_next     = r_tx_data;
    w_bad_cnt_next     = r_bad_cnt;
    w_timeout_next     = r_timeout;
    unique case (r_state)
      StIdle: begin
        w_channel_sel_next = 3'd0;
        if (w_edge) begin
          w_state_next     = StSelect;
          w_cmd_next       = bus.rx_data;
          w_cmd_valid_next = w_cmd_in_valid;
          w_timer_next     = '0;
          if (w_cmd_in_valid) begin
            w_channel_sel_next = bus.rx_data[2:0];
          end else if (r_bad_cnt != 8'hFF) begin
            w_bad_cnt_next = r_bad_cnt + 8'd1;
          end
        end
      end
      StSelect: begin
        if (r_timer == SettleLast) begin
          w_state_next = StLatch;
        end else begin
          w_timer_next = r_timer + TimerW'(1);
        end
      end
      StLatch: begin
        if (r_cmd_valid) w_value_next = bus.max_value;
        w_idx_next     = 3'd0;
        w_tx_data_next = HEADER;
        w_timer_next   = '0;
        w_state_next   = StLoad;
      end
      StLoad: begin
        if (!bus.tx_ready) begin
          w_state_next = StWaitDone;
          w_timer_next = '0;
        end else if (r_timer == TimeoutLast) begin
          w_timeout_next     = 1'b1;
          w_channel_sel_next = 3'd0;
          w_state_next       = StIdle;
        end else begin
          w_timer_next = r_timer + TimerW'(1);
        end
      end
      StWaitDone: begin
        if (bus.tx_ready) begin
          if (r_idx == 3'd4) begin
            w_channel_sel_next = 3'd0;
            w_state_next       = StIdle;
          end else begin
            w_idx_next     = r_idx + 3'd1;
            w_tx_data_next = w_next_byte;
            w_timer_next   = '0;
            w_state_next   = StLoad;
          end
        end else if (r_timer == TimeoutLast) begin
          w_timeout_next     = 1'b1;
          w_channel_sel_next = 3'd0;
          w_state_next       = StIdle;
        end else begin
          w_timer_next = r_timer + TimerW'(1);
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_b) begin
      r_state         <= StIdle;
      r_rx_ready_prev <= 1'b0;
      r_cmd           <= 8'h00;
      r_cmd_valid     <= 1'b0;
      r_channel_sel   <= 3'd0;
      r_value         <= 10'd0;
      r_idx           <= 3'd0;
      r_timer         <= '0;
      r_tx_data       <= 8'h00;
      r_bad_cnt       <= 8'h00;
      r_timeout       <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_rx_ready_prev <= bus.rx_ready;
      r_cmd           <= w_cmd_next;
      r_cmd_valid     <= w_cmd_valid_next;
      r_channel_sel   <= w_channel_sel_next;
      r_value         <= w_value_next;
      r_idx           <= w_idx_next;
      r_timer         <= w_timer_next;
      r_tx_data       <= w_tx_data_next;
      r_bad_cnt       <= w_bad_cnt_next;
      r_timeout       <= w_timeout_next;
    end
  end

  assign bus.channel_sel   = r_channel_sel;
  assign bus.tx_data       = r_tx_data;
  assign bus.tx_en         = (r_state == StLoad);
  assign bus.tx_write_en   = (r_state == StLoad);
  assign bus.busy          = (r_state != StIdle);
  assign bus.bad_cmd_count = r_bad_cnt;
  assign bus.timeout_flag  = r_timeout;

endmodule

// File: tb/tb_uart_max_value_framer.sv
// Directed bench for uart_max_value_framer: one default instance plus one with a short TX timeout.
module tb_uart_max_value_framer;
  logic clk;
  logic reset_b;
  int   errors = 0;
  int   checks = 0;

  uart_max_value_framer_if bus ();
  uart_max_value_framer_if bus_to ();

  uart_max_value_framer u_dut (
    .i_clk     (clk),
    .i_reset_b (reset_b),
    .bus       (bus)
  );

  uart_max_value_framer #(.TX_TIMEOUT(16)) u_dut_to (
    .i_clk     (clk),
    .i_reset_b (reset_b),
    .bus       (bus_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] byte_q[$];
  int         restore_cycles = 20;
  bit         model_busy = 1'b0;
  bit         mon_on = 1'b0;
  logic [2:0] exp_chan = 3'd0;
  int         chan_bad = 0;
  int         we_bad = 0;

  // UART TX model: drops tx_ready one cycle after tx_en, restores it restore_cycles later.
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bus.tx_en === 1'b1 && bus.tx_ready) begin
        model_busy = 1'b1;
        byte_q.push_back(bus.tx_data);
        @(posedge clk); #1;
        bus.tx_ready = 1'b0;
        repeat (restore_cycles) @(posedge clk);
        #1;
        bus.tx_ready = 1'b1;
        model_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_on && bus.busy === 1'b1 && bus.channel_sel !== exp_chan) chan_bad++;
    if (bus.tx_write_en !== bus.tx_en || bus_to.tx_write_en !== bus_to.tx_en) we_bad++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [7:0] b, output int lat);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_ready = 1'b1;
    lat = 0;
    while (bus.tx_en !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    bus.rx_ready = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while ((bus.busy !== 1'b0 || model_busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 5000);
  endtask

  task automatic check_pkt(input string tag, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3);
    logic [7:0] exp [5];
    exp[0] = 8'hA5;
    exp[1] = b1;
    exp[2] = b2;
    exp[3] = b3;
    exp[4] = exp[0] ^ exp[1] ^ exp[2] ^ exp[3];
    check({tag, "_len"}, byte_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("%s_b%0d", tag, i), (i < byte_q.size()) ? {24'h0, byte_q[i]} : 32'hDEAD,
            {24'h0, exp[i]});
    end
  endtask

  initial begin
    int lat;
    int n;
    bit ok;
    reset_b          = 1'b0;
    bus.rx_data      = 8'h00;
    bus.rx_ready     = 1'b0;
    bus.max_value    = 10'h000;
    bus_to.rx_data   = 8'h00;
    bus_to.rx_ready  = 1'b0;
    bus_to.max_value = 10'h000;
    bus_to.tx_ready  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_chan", bus.channel_sel, 0);
    check("rst_tx_en", bus.tx_en, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_bad", bus.bad_cmd_count, 0);
    check("rst_timeout", bus.timeout_flag, 0);
    check("rst_tx_data", bus.tx_data, 0);
    reset_b = 1'b1;

    // Timeout: tx_ready never falls on the short-timeout instance.
    @(negedge clk);
    bus_to.rx_data  = 8'h33;
    bus_to.rx_ready = 1'b1;
    n = 0;
    while (bus_to.tx_en !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t4_latency", n, 4);
    n = 0;
    while (bus_to.tx_en === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t4_load_cycles", n, 16);
    check("t4_flag", bus_to.timeout_flag, 1);
    check("t4_busy", bus_to.busy, 0);
    check("t4_chan", bus_to.channel_sel, 0);
    bus_to.rx_ready = 1'b0;
    @(negedge clk);
    bus_to.rx_data  = 8'h31;
    bus_to.rx_ready = 1'b1;
    @(negedge clk);
    check("t4_reaccept_busy", bus_to.busy, 1);
    check("t4_reaccept_chan", bus_to.channel_sel, 1);
    check("t4_flag_sticky", bus_to.timeout_flag, 1);
    bus_to.rx_ready = 1'b0;

    // Valid command '2'.
    bus.max_value = 10'h2C7;
    exp_chan = 3'd2;
    mon_on = 1'b1;
    byte_q.delete();
    send_cmd(8'h32, lat);
    check("t1_latency", lat, 4);
    wait_idle(ok);
    check("t1_done", ok, 1);
    check_pkt("t1", 8'h42, 8'h02, 8'hC7);
    check("t1_busy", bus.busy, 0);
    check("t1_chan_idle", bus.channel_sel, 0);

    // Unknown command.
    exp_chan = 3'd0;
    byte_q.delete();
    send_cmd(8'h5A, lat);
    wait_idle(ok);
    check("t2_done", ok, 1);
    check_pkt("t2", 8'h3F, 8'h00, 8'h5A);
    check("t2_bad", bus.bad_cmd_count, 1);

    // Second edge while byte 2 is in flight is ignored.
    bus.max_value = 10'h155;
    exp_chan = 3'd2;
    byte_q.delete();
    send_cmd(8'h32, lat);
    n = 0;
    while (byte_q.size() < 3 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    bus.rx_data  = 8'h31;
    bus.rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    bus.rx_ready = 1'b0;
    wait_idle(ok);
    check("t3_done", ok, 1);
    check_pkt("t3", 8'h42, 8'h01, 8'h55);
    check("t3_bad", bus.bad_cmd_count, 1);
    repeat (10) @(negedge clk);
    check("t3_still_idle", bus.busy, 0);

    // Saturation of the bad-command counter (260 total).
    exp_chan = 3'd0;
    restore_cycles = 2;
    for (int i = 0; i < 259; i++) begin
      send_cmd(8'h5A, lat);
      wait_idle(ok);
    end
    check("t2_saturate", bus.bad_cmd_count, 255);

    // Value is frozen at LATCH.
    restore_cycles = 20;
    bus.max_value = 10'h3FF;
    exp_chan = 3'd4;
    byte_q.delete();
    send_cmd(8'h34, lat);
    bus.max_value = 10'h000;
    wait_idle(ok);
    check("t6_done", ok, 1);
    check_pkt("t6", 8'h44, 8'h03, 8'hFF);
    mon_on = 1'b0;

    // Reset during WAIT_DONE of byte 1.
    bus.max_value = 10'h0AB;
    byte_q.delete();
    send_cmd(8'h31, lat);
    n = 0;
    while (!(byte_q.size() >= 2 && bus.tx_en === 1'b0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("t5_reach_wait", bus.busy, 1);
    reset_b = 1'b0;
    @(negedge clk);
    check("t5_chan", bus.channel_sel, 0);
    check("t5_tx_en", bus.tx_en, 0);
    check("t5_tx_we", bus.tx_write_en, 0);
    check("t5_busy", bus.busy, 0);
    check("t5_tx_data", bus.tx_data, 0);
    check("t5_bad", bus.bad_cmd_count, 0);
    reset_b = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.tx_en !== 1'b0) n++;
    end
    check("t5_no_tx_en", n, 0);
    check("t5_bytes", byte_q.size(), 2);

    check("chan_held", chan_bad, 0);
    check("tx_we_eq_en", we_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
